// File: rtl/slot_memory_responder_if.sv
// External RAM request/response port shared with the memory controller.
// The responder drives the request side (master); the controller answers
// with read data and a one-cycle ready (slave).
interface slot_memory_responder_if #(
    parameter int ADDR_WIDTH = 27
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]            ram_din;
    logic                  ram_rd;
    logic                  ram_wr;
    logic [7:0]            ram_dout;
    logic                  ram_ready;

    modport master (
        output ram_addr, ram_din, ram_rd, ram_wr,
        input  ram_dout, ram_ready
    );

    modport slave (
        input  ram_addr, ram_din, ram_rd, ram_wr,
        output ram_dout, ram_ready
    );
endinterface

// File: rtl/slot_memory_responder.sv
// Memory-side responder for the slot/mapper subsystem. Executes one CPU
// access at a time against either the external RAM port (req/ready) or the
// backup-SRAM block RAM (1-cycle read latency), holds the CPU with cpu_wait
// until read data is latched, and returns 0xFF when nothing responds.
module slot_memory_responder #(
    parameter int ADDR_WIDTH      = 27,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int TIMEOUT         = 255
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,

    input  logic                       cpu_req,
    input  logic                       cpu_rd,
    input  logic                       cpu_wr,
    input  logic [7:0]                 cpu_din,
    input  logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic                       mem_rnw,
    input  logic                       ram_cs,
    input  logic                       sram_cs,

    output logic [7:0]                 cpu_dout,
    output logic                       cpu_wait,

    slot_memory_responder_if.master    ram_bus,

    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [7:0]                 sram_din,
    output logic                       sram_we,
    input  logic [7:0]                 sram_dout,

    output logic                       timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        RAM_WAIT,
        SRAM_A,
        SRAM_D,
        DONE
    } state_t;

    state_t                  state;
    logic [7:0]              timer;
    logic                    op_read;
    logic [7:0]              data_reg;
    logic                    data_valid;

    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [7:0]              ram_din_q;
    logic                    ram_rd_q;
    logic                    ram_wr_q;

    // Request decode. SRAM select wins over RAM select; reads win over
    // writes; writes into a write-protected region decode to nothing.
    logic sel_sram;
    logic sel_ram;
    logic do_sram_rd;
    logic do_sram_wr;
    logic do_ram_rd;
    logic do_ram_wr;
    logic accept;

    assign sel_sram   = sram_cs;
    assign sel_ram    = ram_cs && !sram_cs;
    assign do_sram_rd = sel_sram && cpu_rd;
    assign do_sram_wr = sel_sram && !cpu_rd && cpu_wr && !mem_rnw;
    assign do_ram_rd  = sel_ram  && cpu_rd;
    assign do_ram_wr  = sel_ram  && !cpu_rd && cpu_wr && !mem_rnw;
    assign accept     = reset_n && (state == IDLE) && cpu_req;

    // Wait is raised combinationally in the request cycle so the CPU is held
    // before the first registered state change can take effect.
    assign cpu_wait = (state == RAM_WAIT) || (state == SRAM_A) || (state == SRAM_D) ||
                      (accept && (do_sram_rd || do_ram_rd || do_ram_wr));

    assign cpu_dout = data_valid ? data_reg : 8'hFF;

    assign ram_bus.ram_addr = ram_addr_q;
    assign ram_bus.ram_din  = ram_din_q;
    assign ram_bus.ram_rd   = ram_rd_q;
    assign ram_bus.ram_wr   = ram_wr_q;

    // Access sequencer: accepts requests in IDLE, runs the SRAM or RAM
    // transaction, captures read data and manages the sticky timeout flag.
    always_ff @(posedge clk_sys) begin
        // NOTE: every register here uses <= so all updates in this block see
        // the pre-edge values; blocking = would create order-dependent state.
        if (!reset_n) begin
            state       <= IDLE;
            timer       <= '0;
            op_read     <= 1'b0;
            data_reg    <= '0;
            data_valid  <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            sram_addr   <= '0;
            sram_din    <= '0;
            sram_we     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            ram_rd_q <= 1'b0;
            ram_wr_q <= 1'b0;
            sram_we  <= 1'b0;

            // Read data stays visible only while the CPU keeps its read level.
            if (data_valid && !cpu_rd) begin
                data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (do_sram_rd) begin
                            sram_addr  <= mem_addr[SRAM_ADDR_WIDTH-1:0];
                            data_valid <= 1'b0;
                            state      <= SRAM_A;
                        end else if (do_sram_wr) begin
                            sram_addr <= mem_addr[SRAM_ADDR_WIDTH-1:0];
                            sram_din  <= cpu_din;
                            sram_we   <= 1'b1;
                        end else if (do_ram_rd) begin
                            ram_addr_q <= mem_addr;
                            ram_rd_q   <= 1'b1;
                            timer      <= '0;
                            op_read    <= 1'b1;
                            data_valid <= 1'b0;
                            state      <= RAM_WAIT;
                        end else if (do_ram_wr) begin
                            ram_addr_q <= mem_addr;
                            ram_din_q  <= cpu_din;
                            ram_wr_q   <= 1'b1;
                            timer      <= '0;
                            op_read    <= 1'b0;
                            state      <= RAM_WAIT;
                        end
                    end
                end

                // Block RAM sees the address this cycle; data arrives next.
                SRAM_A: state <= SRAM_D;

                SRAM_D: begin
                    data_reg   <= sram_dout;
                    data_valid <= 1'b1;
                    state      <= DONE;
                end

                RAM_WAIT: begin
                    if (ram_bus.ram_ready) begin
                        if (op_read) begin
                            data_reg   <= ram_bus.ram_dout;
                            data_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (timer == 8'(TIMEOUT - 1)) begin
                        // Abort: a read returns the open-bus value.
                        timeout_err <= 1'b1;
                        if (op_read) begin
                            data_reg   <= 8'hFF;
                            data_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_memory_responder.sv
// Directed bench for slot_memory_responder: SRAM read/write, RAM read/write,
// write protect, select priority, unmapped access, timeout and reset abort.
module tb_slot_memory_responder;

    localparam int AW  = 27;
    localparam int SAW = 18;

    logic           clk_sys;
    logic           reset_n;
    logic           cpu_req;
    logic           cpu_rd;
    logic           cpu_wr;
    logic [7:0]     cpu_din;
    logic [AW-1:0]  mem_addr;
    logic           mem_rnw;
    logic           ram_cs;
    logic           sram_cs;
    logic [7:0]     cpu_dout;
    logic           cpu_wait;
    logic [SAW-1:0] sram_addr;
    logic [7:0]     sram_din;
    logic           sram_we;
    logic [7:0]     sram_dout;
    logic           timeout_err;

    slot_memory_responder_if #(.ADDR_WIDTH(AW)) ram_bus ();

    slot_memory_responder #(
        .ADDR_WIDTH      (AW),
        .SRAM_ADDR_WIDTH (SAW),
        .TIMEOUT         (255)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_din     (cpu_din),
        .mem_addr    (mem_addr),
        .mem_rnw     (mem_rnw),
        .ram_cs      (ram_cs),
        .sram_cs     (sram_cs),
        .cpu_dout    (cpu_dout),
        .cpu_wait    (cpu_wait),
        .ram_bus     (ram_bus),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .sram_we     (sram_we),
        .sram_dout   (sram_dout),
        .timeout_err (timeout_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Backup-SRAM block RAM model with registered read.
    logic [7:0] bram [0:(1<<SAW)-1];
    always @(posedge clk_sys) begin
        if (sram_we) bram[sram_addr] <= sram_din;
        sram_dout <= bram[sram_addr];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle helpers: inputs change just after the rising edge, outputs are
    // sampled on the falling edge of the same cycle.
    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_sys);
    endtask

    task automatic bus_idle();
        cpu_req  = 1'b0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        cpu_din  = 8'h00;
        mem_addr = '0;
        mem_rnw  = 1'b0;
        ram_cs   = 1'b0;
        sram_cs  = 1'b0;
        ram_bus.ram_ready = 1'b0;
        ram_bus.ram_dout  = 8'h00;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    int  waits;
    bit  done;

    initial begin
        for (int i = 0; i < (1 << SAW); i++) bram[i] = 8'h00;
        bram[18'h00123] = 8'h5A;
        bus_idle();
        reset_n = 1'b0;
        gap(3);

        // ---- reset state ----
        mid();
        check("rst_cpu_wait",    cpu_wait, 0);
        check("rst_cpu_dout",    cpu_dout, 8'hFF);
        check("rst_ram_rd",      ram_bus.ram_rd, 0);
        check("rst_ram_wr",      ram_bus.ram_wr, 0);
        check("rst_sram_we",     sram_we, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_ram_addr",    ram_bus.ram_addr, 0);
        next_cycle();
        reset_n = 1'b1;
        gap(2);

        // ---- SRAM read: wait T0-T2, data at T3 ----
        cpu_req = 1; cpu_rd = 1; sram_cs = 1; mem_addr = 27'h0000123;
        mid(); check("srd_wait_t0", cpu_wait, 1);
        next_cycle(); cpu_req = 0;
        mid(); check("srd_wait_t1", cpu_wait, 1);
        check("srd_addr_t1", sram_addr, 18'h00123);
        check("srd_we_t1",   sram_we, 0);
        next_cycle();
        mid(); check("srd_wait_t2", cpu_wait, 1);
        next_cycle();
        mid(); check("srd_wait_t3", cpu_wait, 0);
        check("srd_dout_t3", cpu_dout, 8'h5A);
        next_cycle(); cpu_rd = 0;
        next_cycle();
        mid(); check("srd_dout_released", cpu_dout, 8'hFF);
        bus_idle(); gap(2);

        // ---- SRAM write (no wait), then read it back ----
        cpu_req = 1; cpu_wr = 1; sram_cs = 1; mem_addr = 27'h0000456; cpu_din = 8'h3C;
        mid(); check("swr_wait_t0", cpu_wait, 0);
        next_cycle(); bus_idle();
        mid(); check("swr_we_t1",  sram_we, 1);
        check("swr_din_t1", sram_din, 8'h3C);
        check("swr_addr_t1", sram_addr, 18'h00456);
        next_cycle();
        mid(); check("swr_we_t2", sram_we, 0);
        next_cycle();
        cpu_req = 1; cpu_rd = 1; sram_cs = 1; mem_addr = 27'h0000456;
        next_cycle(); cpu_req = 0;
        gap(2);
        mid(); check("swr_readback", cpu_dout, 8'h3C);
        next_cycle(); bus_idle(); gap(2);

        // ---- RAM read: ready at T5 with 0xC3, data at T6 ----
        cpu_req = 1; cpu_rd = 1; ram_cs = 1; mem_addr = 27'h1234567;
        mid(); check("rrd_wait_t0", cpu_wait, 1);
        next_cycle(); cpu_req = 0;
        mid(); check("rrd_rd_t1",   ram_bus.ram_rd, 1);
        check("rrd_addr_t1", ram_bus.ram_addr, 27'h1234567);
        next_cycle();
        mid(); check("rrd_rd_t2",   ram_bus.ram_rd, 0);
        check("rrd_wait_t2", cpu_wait, 1);
        gap(3);
        ram_bus.ram_ready = 1; ram_bus.ram_dout = 8'hC3;
        mid(); check("rrd_wait_t5", cpu_wait, 1);
        next_cycle(); ram_bus.ram_ready = 0; ram_bus.ram_dout = 8'h00;
        mid(); check("rrd_wait_t6", cpu_wait, 0);
        check("rrd_dout_t6", cpu_dout, 8'hC3);
        next_cycle(); bus_idle(); gap(2);

        // ---- write protect: RAM write with mem_rnw=1 is dropped ----
        cpu_req = 1; cpu_wr = 1; ram_cs = 1; mem_rnw = 1; mem_addr = 27'h0000ABC; cpu_din = 8'h77;
        mid(); check("wp_wait_t0", cpu_wait, 0);
        next_cycle(); cpu_req = 0;
        mid(); check("wp_wr_t1",   ram_bus.ram_wr, 0);
        check("wp_wait_t1", cpu_wait, 0);
        next_cycle(); bus_idle(); gap(1);

        // ---- same RAM write with mem_rnw=0 ----
        cpu_req = 1; cpu_wr = 1; ram_cs = 1; mem_rnw = 0; mem_addr = 27'h0000ABC; cpu_din = 8'h77;
        mid(); check("rwr_wait_t0", cpu_wait, 1);
        next_cycle(); cpu_req = 0;
        mid(); check("rwr_wr_t1",   ram_bus.ram_wr, 1);
        check("rwr_din_t1",  ram_bus.ram_din, 8'h77);
        check("rwr_addr_t1", ram_bus.ram_addr, 27'h0000ABC);
        next_cycle(); ram_bus.ram_ready = 1;
        mid(); check("rwr_wr_t2", ram_bus.ram_wr, 0);
        next_cycle(); ram_bus.ram_ready = 0;
        mid(); check("rwr_wait_t3", cpu_wait, 0);
        check("rwr_dout_t3", cpu_dout, 8'hFF);
        next_cycle(); bus_idle(); gap(2);

        // ---- priority: both selects, SRAM path only ----
        cpu_req = 1; cpu_rd = 1; ram_cs = 1; sram_cs = 1; mem_addr = 27'h4000123;
        next_cycle(); cpu_req = 0;
        mid(); check("prio_ram_rd_t1", ram_bus.ram_rd, 0);
        check("prio_sram_addr",  sram_addr, 18'h00123);
        gap(2);
        mid(); check("prio_dout_t3", cpu_dout, 8'h5A);
        check("prio_wait_t3", cpu_wait, 0);
        next_cycle(); bus_idle(); gap(2);

        // ---- unmapped read ----
        cpu_req = 1; cpu_rd = 1; mem_addr = 27'h0000123;
        mid(); check("unmap_wait_t0", cpu_wait, 0);
        next_cycle(); cpu_req = 0;
        mid(); check("unmap_strobes_t1", {ram_bus.ram_rd, ram_bus.ram_wr, sram_we}, 3'b000);
        check("unmap_wait_t1", cpu_wait, 0);
        next_cycle();
        mid(); check("unmap_dout_t2", cpu_dout, 8'hFF);
        next_cycle(); bus_idle(); gap(2);

        // ---- timeout: no ready, wait high for 256 cycles ----
        cpu_req = 1; cpu_rd = 1; ram_cs = 1; mem_addr = 27'h0100000;
        mid();
        waits = 0;
        done  = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (cpu_wait) begin
                waits++;
                next_cycle();
                cpu_req = 0;
                mid();
            end else begin
                done = 1;
            end
        end
        check("to_wait_cycles", waits, 256);
        check("to_dout",        cpu_dout, 8'hFF);
        check("to_err",         timeout_err, 1);
        next_cycle(); bus_idle(); gap(2);

        // ---- timeout_err is sticky across a good RAM read ----
        cpu_req = 1; cpu_rd = 1; ram_cs = 1; mem_addr = 27'h0000010;
        next_cycle(); cpu_req = 0;
        next_cycle(); ram_bus.ram_ready = 1; ram_bus.ram_dout = 8'h96;
        next_cycle(); ram_bus.ram_ready = 0;
        mid(); check("sticky_dout", cpu_dout, 8'h96);
        check("sticky_err",  timeout_err, 1);
        next_cycle(); bus_idle(); gap(2);

        // ---- reset in RAM_WAIT, then a late ready ----
        cpu_req = 1; cpu_rd = 1; ram_cs = 1; mem_addr = 27'h0ABCDEF;
        next_cycle(); cpu_req = 0;
        gap(2);
        reset_n = 0;
        next_cycle();
        reset_n = 1; ram_bus.ram_ready = 1; ram_bus.ram_dout = 8'hAA;
        mid(); check("rstmid_wait",  cpu_wait, 0);
        check("rstmid_rd",    ram_bus.ram_rd, 0);
        check("rstmid_err",   timeout_err, 0);
        check("rstmid_addr",  ram_bus.ram_addr, 0);
        next_cycle(); ram_bus.ram_ready = 0;
        mid(); check("rstmid_dout", cpu_dout, 8'hFF);
        check("rstmid_wait_after", cpu_wait, 0);
        next_cycle(); bus_idle(); gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
